inst_buffer: RTL and testbench

//   Fetch buffer between inst_fetch and decode. Circular FIFO of fb_entry_t {inst, pc}.

---
 rtl/inst_buffer.sv | 97 +++++++++
 tb/tb_inst_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// Fetch buffer: circular FIFO of {inst, pc} between fetch and decode.
// First-word fall-through to decode, conservative stall to fetch, flush on redirect.
package inst_buffer_pkg;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fb_entry_t;
endpackage

module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int FETCH_WIDTH  = 1,
  parameter int DECODE_WIDTH = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                flush,
  input  fb_entry_t [FETCH_WIDTH-1:0]         insts_in,
  input  logic                                insts_in_valid,
  output logic                                stall,
  output fb_entry_t [DECODE_WIDTH-1:0]        insts_out,
  output logic      [DECODE_WIDTH-1:0]        insts_out_valid,
  input  logic                                decode_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FW_C    = CW'(FETCH_WIDTH);

  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [CW-1:0] pop_n;
  logic          push_en;

  fb_entry_t entry [DEPTH];

  // Stall looks only at the registered count, so fetch never
  // sees a combinational path through decode_ready.
  assign stall   = (DEPTH_C - count) < FW_C;
  assign push_en = insts_in_valid & ~stall & ~flush;

  // Head window presented to decode; valid bits form a thermometer.
  always_comb begin
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      insts_out[i]       = entry[head_ptr + PW'(i)];
      insts_out_valid[i] = (count > CW'(i)) & ~flush;
    end
  end

  // Decode takes every valid slot when ready; count how many.
  always_comb begin
    pop_n = '0;
    if (decode_ready & ~flush) begin
      for (int i = 0; i < DECODE_WIDTH; i++) begin
        pop_n = pop_n + CW'(insts_out_valid[i]);
      end
    end
  end

  assign count_next = count
                    + (push_en ? FW_C : '0)
                    - pop_n;

  // Pointer and occupancy update; reset beats flush beats push/pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push_en) begin
        tail_ptr <= tail_ptr + PW'(FETCH_WIDTH);
      end
      head_ptr <= head_ptr + pop_n[PW-1:0];
      count    <= count_next;
    end
  end

  // Write the fetch group at the tail; a group may straddle the wrap point.
  always_ff @(posedge clock) begin
    if (push_en & ~reset) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        entry[tail_ptr + PW'(i)] <= insts_in[i];
      end
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: driver pushes accepted entries into
// an expected queue, a negedge monitor pops and compares decode output.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int DEPTH = 16;
  localparam int FW    = 1;
  localparam int DW    = 2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 flush;
  fb_entry_t [FW-1:0]   insts_in;
  logic                 insts_in_valid;
  logic                 stall;
  fb_entry_t [DW-1:0]   insts_out;
  logic      [DW-1:0]   insts_out_valid;
  logic                 decode_ready;

  fb_entry_t   exp_q[$];
  int          checks = 0;
  int          passed = 0;
  logic [31:0] next_pc;
  logic        acc;

  inst_buffer #(
    .DEPTH(DEPTH),
    .FETCH_WIDTH(FW),
    .DECODE_WIDTH(DW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .insts_in(insts_in),
    .insts_in_valid(insts_in_valid),
    .stall(stall),
    .insts_out(insts_out),
    .insts_out_valid(insts_out_valid),
    .decode_ready(decode_ready)
  );

  always #5 clock = ~clock;

  function automatic void check(string name, logic [63:0] act,
                                logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endfunction

  // Monitor: expected outputs come from the queue of accepted entries.
  always @(negedge clock) begin
    int n;
    logic [DW-1:0] th;
    if (!reset) begin
      n = flush ? 0 : ((exp_q.size() < DW) ? exp_q.size() : DW);
      th = '0;
      for (int i = 0; i < n; i++) th[i] = 1'b1;
      check("stall", stall, 64'((DEPTH - exp_q.size()) < FW));
      check("valid", insts_out_valid, th);
      if (decode_ready) begin
        for (int i = 0; i < n; i++) begin
          fb_entry_t e;
          e = exp_q.pop_front();
          check("out_entry", insts_out[i], e);
        end
      end
    end
  end

  task automatic set_in(input logic v, input logic rdy,
                        input logic fl, input logic rs);
    insts_in_valid = v;
    decode_ready   = rdy;
    flush          = fl;
    reset          = rs;
    for (int i = 0; i < FW; i++) begin
      insts_in[i].pc   = next_pc + 32'(4 * i);
      insts_in[i].inst = $urandom();
    end
    acc = v & ~fl & ~rs & ((DEPTH - exp_q.size()) >= FW);
  endtask

  task automatic end_cycle();
    @(negedge clock);
    #1;
    if (reset || flush) exp_q.delete();
    else if (acc) begin
      for (int i = 0; i < FW; i++) exp_q.push_back(insts_in[i]);
    end
    if (insts_in_valid) next_pc = next_pc + 32'(4 * FW);
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic v, input logic rdy,
                      input logic fl, input logic rs);
    set_in(v, rdy, fl, rs);
    end_cycle();
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    insts_in_valid = 1'b0;
    decode_ready = 1'b0;
    insts_in = '0;
    next_pc = '0;
    acc = 1'b0;
    @(posedge clock);
    #1;

    // T1 reset with fetch offering
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    set_in(0, 0, 0, 0);
    #1;
    check("t1_stall", stall, 0);
    check("t1_valid", insts_out_valid, 0);
    end_cycle();

    // T2 fill to full, 17th dropped
    next_pc = '0;
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
    set_in(1, 0, 0, 0);
    #1;
    check("t2_stall", stall, 1);
    check("t2_head_pc", insts_out[0].pc, 0);
    check("t2_valid", insts_out_valid, 2'b11);
    end_cycle();

    // T3 drain
    set_in(0, 1, 0, 0);
    #1;
    check("t3_stall_first_pop", stall, 1);
    end_cycle();
    set_in(0, 1, 0, 0);
    #1;
    check("t3_stall_dropped", stall, 0);
    check("t3_pc", insts_out[0].pc, 32'h8);
    end_cycle();
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    set_in(0, 0, 0, 0);
    #1;
    check("t3_empty", insts_out_valid, 0);
    end_cycle();

    // T4 concurrent push/pop with wrap
    for (int i = 0; i < 40; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    set_in(0, 0, 0, 0);
    #1;
    check("t4_empty", insts_out_valid, 0);
    end_cycle();

    // T5 flush mid-stream
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    set_in(1, 1, 1, 0);
    #1;
    check("t5_valid_flush", insts_out_valid, 0);
    check("t5_stall", stall, 0);
    end_cycle();
    set_in(0, 0, 0, 0);
    #1;
    check("t5_empty", insts_out_valid, 0);
    end_cycle();
    next_pc = 32'h800;
    step(1, 0, 0, 0);
    set_in(0, 0, 0, 0);
    #1;
    check("t5_valid_one", insts_out_valid, 2'b01);
    check("t5_pc", insts_out[0].pc, 32'h800);
    end_cycle();
    step(0, 1, 0, 0);

    // T6 reset mid-operation
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    step(0, 1, 1, 1);
    set_in(0, 0, 0, 0);
    #1;
    check("t6_stall", stall, 0);
    check("t6_valid", insts_out_valid, 0);
    end_cycle();
    next_pc = 32'h100;
    step(1, 0, 0, 0);
    set_in(0, 1, 0, 0);
    #1;
    check("t6_valid_one", insts_out_valid, 2'b01);
    check("t6_pc", insts_out[0].pc, 32'h100);
    end_cycle();

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 49) == 0,
           1'b0);
    end
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
